// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential multiplier.
package mult_pkg;

  localparam int ITER  = 16;  // one iteration per multiplier bit
  localparam int CNT_W = 5;   // iteration counter width, holds 0..16

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/rca_16bit.sv
// 16-bit ripple-carry adder: {carry, sum} = a + b + carry_start.
module rca_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_start,
  output logic [15:0] sum,
  output logic        carry
);

  logic [16:0] c;

  assign c[0] = carry_start;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign carry = c[16];

endmodule

// File: rtl/seq_mult_16bit.sv
// 16x16 unsigned shift-and-add multiplier, one partial product per cycle.
// A/Q form a 32-bit shift register; the adder result and its carry are
// shifted back in so the carry lands in A[15].
module seq_mult_16bit
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_carry;
  logic [2*WIDTH:0]   shifted;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign add_b = q_q[0] ? m_q : '0;

  rca_16bit u_rca (
    .a           (acc_q),
    .b           (add_b),
    .carry_start (1'b0),
    .sum         (add_sum),
    .carry       (add_carry)
  );

  // 33-bit {C,S,Q} shifted right once; bit 32 is always zero afterwards.
  assign shifted = {add_carry, add_sum, q_q} >> 1;

  // Next-state, datapath and result-register update.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = shifted[2*WIDTH-1:WIDTH];
        q_d   = shifted[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d   = DONE;
          product_d = shifted[2*WIDTH-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q == CALC) || (state_q == DONE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seq_mult_16bit.sv
// Directed bench for seq_mult_16bit: latency, products, handshake, reset.
module tb_seq_mult_16bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic [31:0] product;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  seq_mult_16bit #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation from IDLE and observe it; no checking here.
  // lat = edges after the start edge until done is seen (-1 on timeout),
  // busy_gap = busy was low before done, done_w = cycles done stayed high,
  // busy_after = busy one cycle after the done cycle.
  task automatic launch_and_wait(input logic [15:0] aa, input logic [15:0] bb,
                                 output int lat, output logic [31:0] prod,
                                 output int busy_gap, output int done_w,
                                 output logic busy_after);
    lat = -1; prod = 'x; busy_gap = 0; done_w = 0; busy_after = 1'bx;
    a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat  = i;
        prod = product;
        done_w = 1;
        @(posedge clk); #1;
        if (done) done_w = 2;
        busy_after = busy;
        break;
      end
      if (!busy) busy_gap = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      bad++;
      $display("FAIL reset_state busy=%b done=%b product=%h want 0/0/0", busy, done, product);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, gap, dw; logic [31:0] p; logic ba;
    launch_and_wait(16'h0003, 16'h0005, lat, p, gap, dw, ba);
    total++;
    if (lat !== 16) begin bad++; $display("FAIL basic_latency got=%0d want=16", lat); end
    total++;
    if (p !== 32'h0000_000F) begin bad++; $display("FAIL basic_product got=%h want=0000000f", p); end
    total++;
    if (dw !== 1) begin bad++; $display("FAIL basic_done_width got=%0d want=1", dw); end
    total++;
    if (gap !== 0 || ba !== 1'b0) begin
      bad++; $display("FAIL basic_busy gap=%0d busy_after=%b want 0/0", gap, ba);
    end
    total++;
    if (product !== 32'h0000_000F) begin bad++; $display("FAIL basic_hold got=%h want=0000000f", product); end
  endtask

  task automatic test_vectors();
    logic [15:0] va [4] = '{16'hFFFF, 16'h0000, 16'h8000, 16'h1234};
    logic [15:0] vb [4] = '{16'hFFFF, 16'h1234, 16'h0002, 16'h0001};
    logic [31:0] vp [4] = '{32'hFFFE_0001, 32'h0000_0000, 32'h0001_0000, 32'h0000_1234};
    int lat, gap, dw; logic [31:0] p; logic ba;
    for (int k = 0; k < 4; k++) begin
      launch_and_wait(va[k], vb[k], lat, p, gap, dw, ba);
      total++;
      if (lat !== 16 || p !== vp[k]) begin
        bad++;
        $display("FAIL vector%0d %h*%h got=%h lat=%0d want=%h lat=16", k, va[k], vb[k], p, lat, vp[k]);
      end
    end
  endtask

  // start held high across a whole operation with a/b changing underneath.
  task automatic test_start_held();
    int first = -1, second = -1;
    logic [31:0] p1 = 'x, p2 = 'x;
    logic idle_seen = 1'b0;
    a = 16'h0003; b = 16'h0005; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h0007; b = 16'h0009;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (i == 17 && !busy) idle_seen = 1'b1;
      if (done && first < 0) begin first = i; p1 = product; end
      else if (done && second < 0) begin second = i; p2 = product; break; end
    end
    start = 1'b0;
    total++;
    if (first !== 16 || p1 !== 32'h0000_000F) begin
      bad++; $display("FAIL held_first got=%h at=%0d want=0000000f at=16", p1, first);
    end
    total++;
    if (!idle_seen) begin bad++; $display("FAIL held_busy_drop busy at edge17=1 want 0"); end
    total++;
    if (second !== 34 || p2 !== 32'h0000_003F) begin
      bad++; $display("FAIL held_second got=%h at=%0d want=0000003f at=34", p2, second);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, gap, dw; logic [31:0] p; logic ba;
    a = 16'h0003; b = 16'h0005; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset busy=%b done=%b product=%h want 0/0/0", busy, done, product);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    launch_and_wait(16'h00FF, 16'h0101, lat, p, gap, dw, ba);
    total++;
    if (lat !== 16 || p !== 32'h0000_FFFF) begin
      bad++; $display("FAIL post_reset got=%h lat=%0d want=0000ffff lat=16", p, lat);
    end
  endtask

  task automatic test_random();
    int lat, gap, dw; logic [31:0] p, exp_p; logic ba;
    logic [15:0] ra, rb;
    for (int k = 0; k < 48; k++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      exp_p = 32'(ra) * 32'(rb);
      launch_and_wait(ra, rb, lat, p, gap, dw, ba);
      total++;
      if (lat !== 16 || p !== exp_p || dw !== 1 || gap !== 0 || ba !== 1'b0) begin
        bad++;
        $display("FAIL random%0d %h*%h got=%h lat=%0d dw=%0d gap=%0d want=%h lat=16 dw=1 gap=0",
                 k, ra, rb, p, lat, dw, gap, exp_p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
